// File: rtl/parallel_sample_serializer.sv
// -----------------------------------------------------------------------------
// parallel_sample_serializer
//
// Splits each wide multi-lane sample word from the parallel DDS into a stream
// of one sample per beat, lane 0 first. A single word is held while its lanes
// are emitted. The next word can be accepted in the same cycle that the last
// lane is handed off, so the output runs gapless at one sample per clock.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   parallel sample word, lane k = bits [DW*(k+1)-1 : DW*k]
//   s_axis_tvalid  input word valid
//   s_axis_tready  word can be accepted this cycle
//   m_axis_tdata   current serial sample
//   m_axis_tvalid  serial sample valid
//   m_axis_tready  downstream accepts the sample
//   m_axis_tlast   high on the lane CHANNELS-1 beat of each word
//   m_axis_lane    lane index of the current sample
//
// FSM states
//   state | meaning
//   EMPTY | no word held; accept a new word when ready_en is set
//   BUSY  | word held in r_hold; lane r_lane is presented on the output
//
// Note: s_axis_tready depends combinationally on m_axis_tready, which is how
// the last lane of one word and the first lane of the next can hand off in
// the same cycle. Upstream must not derive s_axis_tvalid from s_axis_tready.
// -----------------------------------------------------------------------------
module parallel_sample_serializer #(
  parameter int CHANNELS   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LANE_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH*CHANNELS-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [LANE_W-1:0]              m_axis_lane
);

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(CHANNELS - 1);

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [DATA_WIDTH*CHANNELS-1:0] r_hold;
  logic [LANE_W-1:0]              r_lane;
  logic [LANE_W-1:0]              w_lane_nxt;
  logic                           r_ready_en;
  logic                           w_load;
  logic                           w_in_hs;
  logic                           w_out_hs;
  logic                           w_last;
  logic [DATA_WIDTH-1:0]          w_lane_data;

  // Output view of the held word
  assign w_last        = (r_state == BUSY) && (r_lane == LAST_LANE);
  assign m_axis_tvalid = (r_state == BUSY);
  assign m_axis_tlast  = w_last;
  assign m_axis_lane   = r_lane;
  assign m_axis_tdata  = w_lane_data;

  // Lane mux written as a compare loop so it stays clean for any CHANNELS,
  // including counts that are not a power of two.
  always_comb begin
    w_lane_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_lane == LANE_W'(k)) begin
        w_lane_data = r_hold[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready when empty, or when the final lane is leaving this very cycle.
  assign w_out_hs      = m_axis_tvalid && m_axis_tready;
  assign s_axis_tready = r_ready_en && ((r_state == EMPTY) || (w_out_hs && w_last));
  assign w_in_hs       = s_axis_tvalid && s_axis_tready;

  // ready_en keeps tready low during reset and on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_load      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_hs) begin
          w_load      = 1'b1;
          w_lane_nxt  = '0;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_out_hs) begin
          if (r_lane == LAST_LANE) begin
            w_lane_nxt = '0;
            if (w_in_hs) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = EMPTY;
            end
          end else begin
            w_lane_nxt = r_lane + LANE_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = EMPTY;
        w_lane_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= '0;
    end else begin
      r_lane <= w_lane_nxt;
    end
  end

  // The held word is left stale after the last lane; it is not visible
  // because valid is low in EMPTY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_load) begin
      r_hold <= s_axis_tdata;
    end
  end

endmodule

// File: tb/tb_parallel_sample_serializer.sv
module tb_parallel_sample_serializer;

  localparam int CH = 8;
  localparam int DW = 16;

  logic clk;
  logic rst_n;

  // CHANNELS=8 instance
  logic [DW*CH-1:0] s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [2:0]       m_lane;

  // CHANNELS=1 instance
  logic [DW-1:0]    s1_tdata;
  logic             s1_tvalid;
  logic             s1_tready;
  logic [DW-1:0]    m1_tdata;
  logic             m1_tvalid;
  logic             m1_tready;
  logic             m1_tlast;
  logic [0:0]       m1_lane;

  parallel_sample_serializer #(.CHANNELS(CH), .DATA_WIDTH(DW)) u_dut8 (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_lane   (m_lane)
  );

  parallel_sample_serializer #(.CHANNELS(1), .DATA_WIDTH(DW)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s1_tdata),
    .s_axis_tvalid (s1_tvalid),
    .s_axis_tready (s1_tready),
    .m_axis_tdata  (m1_tdata),
    .m_axis_tvalid (m1_tvalid),
    .m_axis_tready (m1_tready),
    .m_axis_tlast  (m1_tlast),
    .m_axis_lane   (m1_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;   // s_axis_tvalid
    int          sw;   // index of word driven on s_axis_tdata
    logic        mr;   // m_axis_tready
    logic        mv;   // expected m_axis_tvalid
    logic [15:0] md;   // expected m_axis_tdata
    logic        ml;   // expected m_axis_tlast
    logic [2:0]  lane; // expected m_axis_lane
    logic        sr;   // expected s_axis_tready
  } vec_t;

  vec_t             vecs[$];
  logic [DW*CH-1:0] words[6];
  int               n_checks;
  int               n_errors;

  // word index: 0=W0 (0x0000+k) 1=A 2=B 3=C 4=D 5=E (base 0x1000*idx + k)
  function automatic logic [DW*CH-1:0] mk_word(input logic [15:0] base);
    logic [DW*CH-1:0] w;
    w = '0;
    for (int k = 0; k < CH; k++) w[k*DW +: DW] = base + 16'(k);
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic sv, input int sw, input logic mr, input logic mv,
                     input logic [15:0] md, input logic ml, input logic [2:0] lane,
                     input logic sr);
    vec_t v;
    v.sv = sv; v.sw = sw; v.mr = mr; v.mv = mv;
    v.md = md; v.ml = ml; v.lane = lane; v.sr = sr;
    vecs.push_back(v);
  endtask

  task automatic chk_outs(input string tag, input logic mv, input logic [15:0] md,
                          input logic ml, input logic [2:0] lane, input logic sr);
    chk({tag, " m_tvalid"}, 32'(m_tvalid), 32'(mv));
    chk({tag, " m_tdata"},  32'(m_tdata),  32'(md));
    chk({tag, " m_tlast"},  32'(m_tlast),  32'(ml));
    chk({tag, " m_lane"},   32'(m_lane),   32'(lane));
    chk({tag, " s_tready"}, 32'(s_tready), 32'(sr));
  endtask

  logic [15:0] exp_q[$];
  logic [15:0] cur_data;
  logic        cur_valid;
  logic [15:0] exp_d;
  int          sent;
  int          rcvd;
  int          cyc;

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 6; i++) words[i] = mk_word(16'(i * 16'h1000));

    // Cycle table; each row is driven after a falling edge and checked
    // before the next rising edge.
    // W0 single word, free-running output
    add(1, 0, 1, 0, 16'h0000, 0, 0, 1);
    for (int k = 0; k < 8; k++)
      add(0, 0, 1, 1, 16'(k), k == 7, 3'(k), k == 7);
    // A then B back-to-back, tvalid held high
    add(1, 1, 1, 0, 16'h0000, 0, 0, 1);
    for (int k = 0; k < 8; k++)
      add(1, 2, 1, 1, 16'h1000 + 16'(k), k == 7, 3'(k), k == 7);
    for (int k = 0; k < 8; k++)
      add(0, 2, 1, 1, 16'h2000 + 16'(k), k == 7, 3'(k), k == 7);
    // C with a three-cycle stall at lane 3; a pending input word is ignored
    add(1, 3, 1, 0, 16'h2000, 0, 0, 1);
    for (int k = 0; k < 3; k++)
      add(0, 3, 1, 1, 16'h3000 + 16'(k), 0, 3'(k), 0);
    for (int s = 0; s < 3; s++)
      add(1, 0, 0, 1, 16'h3003, 0, 3'd3, 0);
    for (int k = 3; k < 8; k++)
      add(0, 0, 1, 1, 16'h3000 + 16'(k), k == 7, 3'(k), k == 7);

    // Reset held with upstream valid asserted
    rst_n     = 1'b0;
    s_tvalid  = 1'b1;
    s_tdata   = words[0];
    m_tready  = 1'b1;
    s1_tvalid = 1'b0;
    s1_tdata  = '0;
    m1_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("rst%0d s_tready", i), 32'(s_tready), 32'd0);
      chk($sformatf("rst%0d m_tvalid", i), 32'(m_tvalid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst edge1 s_tready", 32'(s_tready), 32'd0);
    chk("post-rst edge1 m_tvalid", 32'(m_tvalid), 32'd0);
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    chk("post-rst edge2 s_tready", 32'(s_tready), 32'd1);
    chk("post-rst edge2 m_tvalid", 32'(m_tvalid), 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      s_tvalid = vecs[i].sv;
      s_tdata  = words[vecs[i].sw];
      m_tready = vecs[i].mr;
      #1;
      chk_outs($sformatf("row%0d", i), vecs[i].mv, vecs[i].md, vecs[i].ml,
               vecs[i].lane, vecs[i].sr);
    end

    // Async reset during lane 5 of word D
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = words[4];
    m_tready = 1'b1;
    #1;
    chk("D accept s_tready", 32'(s_tready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      s_tvalid = 1'b0;
      #1;
      chk($sformatf("D lane%0d data", k), 32'(m_tdata), 32'h4000 + 32'(k));
    end
    rst_n = 1'b0;
    #1;
    chk_outs("async-rst", 0, 16'h0000, 0, 3'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst2 edge1 s_tready", 32'(s_tready), 32'd0);
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = words[5];
    #1;
    chk_outs("E accept", 0, 16'h0000, 0, 3'd0, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      s_tvalid = 1'b0;
      #1;
      chk_outs($sformatf("E lane%0d", k), 1, 16'h5000 + 16'(k), k == 7, 3'(k), k == 7);
    end
    @(negedge clk); #1;
    chk("E done m_tvalid", 32'(m_tvalid), 32'd0);

    // CHANNELS=1: 1000 words with random valid/ready, scoreboarded
    sent      = 0;
    rcvd      = 0;
    cyc       = 0;
    cur_valid = 1'b0;
    cur_data  = '0;
    while ((sent < 1000 || rcvd < 1000) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!cur_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        cur_valid = 1'b1;
        cur_data  = 16'($urandom);
      end
      s1_tvalid = cur_valid;
      s1_tdata  = cur_data;
      m1_tready = ($urandom_range(0, 3) != 0);
      #1;
      if (m1_tvalid && m1_tready) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk($sformatf("ch1 beat%0d data", rcvd), 32'(m1_tdata), 32'(exp_d));
        if (m1_tlast !== 1'b1 || m1_lane !== 1'b0)
          chk($sformatf("ch1 beat%0d last/lane", rcvd), {30'd0, m1_tlast, m1_lane}, 32'h2);
        rcvd++;
      end
      if (s1_tvalid && s1_tready) begin
        exp_q.push_back(cur_data);
        sent++;
        cur_valid = 1'b0;
      end
    end
    chk("ch1 words received", 32'(rcvd), 32'd1000);
    chk("ch1 words accepted", 32'(sent), 32'd1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/parallel_sample_serializer.md
Name: parallel_sample_serializer

Overview:
Converts the wide multi-lane sample stream from the parallel DDS into a single-lane stream of one sample per beat. Each input word carries CHANNELS time-ordered samples. The block sits downstream of the parallel DDS output, feeding capture, serial DAC or checker logic running at the sample rate. AXI-Stream style valid/ready on both sides, full throughput of one output sample per clock.

Parameters:
CHANNELS, 8, number of sample lanes per input word; >=1
DATA_WIDTH, 16, bits per sample lane
LANE_W, derived, $clog2(CHANNELS) with minimum 1; width of the lane index

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
s_axis_tdata  input  DATA_WIDTH*CHANNELS  parallel sample word; lane k = bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]; lane 0 is the earliest sample
s_axis_tvalid  input  1  input word valid
s_axis_tready  output  1  block can accept a word this cycle
m_axis_tdata  output  DATA_WIDTH  current serial sample
m_axis_tvalid  output  1  serial sample valid
m_axis_tready  input  1  downstream accepts sample
m_axis_tlast  output  1  high on the lane CHANNELS-1 beat of each word
m_axis_lane  output  LANE_W  lane index of the current sample

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clk is the clock.
- Registers: hold_reg (full word), lane counter, state {EMPTY, BUSY}, ready_en flag.
- Reset values: hold_reg=0, lane=0, state=EMPTY, ready_en=0. So m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_lane=0, s_axis_tready=0.
- ready_en sets to 1 on the first clk edge after rst_n deasserts and stays 1. s_axis_tready is never high during reset or on the first edge after it.
- Combinational outputs:
  - m_axis_tvalid = (state==BUSY).
  - m_axis_tdata = lane slice [lane] of hold_reg.
  - m_axis_tlast = BUSY && lane==CHANNELS-1.
  - m_axis_lane = lane.
  - s_axis_tready = ready_en && (state==EMPTY || (m_axis_tvalid && m_axis_tready && m_axis_tlast)).
- Input handshake: s_axis_tvalid && s_axis_tready. Output handshake: m_axis_tvalid && m_axis_tready.
- EMPTY: on input handshake, load hold_reg, lane<=0, go to BUSY. Otherwise hold.
- BUSY, no output handshake: all registers hold. Output data, lane and last stay stable while stalled.
- BUSY, output handshake, lane<CHANNELS-1: lane<=lane+1.
- BUSY, output handshake, lane==CHANNELS-1:
  - If an input handshake occurs in the same cycle: load the new word, lane<=0, stay BUSY. This gives gapless back-to-back output.
  - Otherwise: go to EMPTY, lane<=0. hold_reg keeps its stale value, which is not observed because valid=0.
- Latency: the first sample appears on the clk edge after the input handshake.
- Throughput: sustains 1 sample/clk. Accepts at most one word every CHANNELS clocks when output is never stalled.
- CHANNELS=1: every beat is last; the block behaves as a one-deep register slice with full throughput.
- Input words are never dropped or duplicated. Sample order is word order, then lane 0..CHANNELS-1.
- s_axis_tdata is sampled only on input handshake. Changes while tready=0 are ignored.
- Reset mid-word: the partially emitted word is discarded. Outputs take their reset values immediately, asynchronously.
- Combinational path m_axis_tready -> s_axis_tready exists by design. Upstream must not make s_axis_tvalid depend on s_axis_tready.

Test Plan:
- Reset/startup: hold rst_n low for 5 clks with s_axis_tvalid=1 -> s_axis_tready=0 and m_axis_tvalid=0 throughout and on the first edge after release. tready=1 from the second edge.
- Single word, CHANNELS=8, DATA_WIDTH=16, lanes 0x0000..0x0007, m_axis_tready=1 -> 8 consecutive beats 0x0000..0x0007. lane 0..7, tlast only on 0x0007. Then valid=0 and s_axis_tready=1.
- Back-to-back words A (0x1000+k) and B (0x2000+k), s_axis_tvalid held high -> 16 gapless beats. B accepted in the same cycle as A's lane 7 handshake; s_axis_tready high for exactly that cycle.
- Output stall: deassert m_axis_tready for 3 clks at lane 3 -> m_axis_tdata=lane-3 value, lane=3 stable for 3 clks. Sequence resumes at lane 4 with no loss; s_axis_tready stays 0.
- Async reset asserted at lane 5 of a word -> outputs drop to 0 immediately. After release, the next accepted word starts at lane 0; no stale lanes are emitted.
- CHANNELS=1 build, random valid/ready backpressure over 1000 words -> output sequence equals input sequence, tlast=1 on every beat, no loss or duplication.
